cond_issue_ctrl: RTL and testbench
==================================

# cond_issue_ctrl

Issue-stage controller that owns the architectural NZCV flags register and gates each decoded instruction's side effects by its 4-bit condition field. It sits between decode and execute. It tracks flag-writing instructions still in flight in the ALU, stalls dependent conditional instructions, and squashes the two wrong-path instructions after a taken branch.

## Interface
- MAX_PEND, 2: max flag-writing instructions in flight (1..4); depth of the flag-mask FIFO.
- FLUSH_SLOTS, 2: wrong-path instructions discarded after a taken branch (1..3).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  controller accepts this cycle; transfer = in_valid & in_ready.
- in_cond  in  4  condition field (EQ=0000 … AL=1110, 1111 undefined).
- in_flagw  in  2  bit1 = update NZ, bit0 = update CV.
- in_regw, in_memw, in_pcs  in  1 each  register write, memory write, PC write.
- alu_flags  in  4  {N,Z,C,V} of the oldest pending flag-writer.
- alu_flags_valid  in  1  alu_flags valid this cycle.
- ex_valid  out  1  instruction issued to execute.
- ex_regw, ex_memw, ex_pcs  out  1 each  side effects, gated by the condition.
- ex_flagw  out  2  gated in_flagw.
- ex_condex  out  1  condition passed.
- branch_taken  out  1  one-cycle pulse on a taken branch.
- flags  out  4  current NZCV register.
- undef_trap  out  1  only with COND_UNDEF_TRAP_EN.

## Operation
- Condition evaluation uses flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~(C&~Z), GE N==V, LT N!=V, GT ~Z&(N==V), LE its inverse, AL 1, 1111 → 0.
- FSM states:
  - RUN: evaluate and issue.
  - FLUSH: discard accepted instructions, count FLUSH_SLOTS, then return to RUN.
- RUN→FLUSH on a transfer with in_pcs & condex.
- In RUN, in_ready = 0 when either holds:
  - in_valid, in_cond != AL and pending != 0 (flag hazard; no forwarding);
  - in_flagw != 0 and pending == MAX_PEND.
- In FLUSH, in_ready = 1 and there is no hazard check.
- On a RUN transfer:
  - ex_* = in_* & condex; ex_flagw = in_flagw & {2{condex}}.
  - If ex_flagw != 0, push the mask and pending += 1.
- On a FLUSH transfer: ex_valid = 0, nothing is pushed, the slot counter decrements.
- On alu_flags_valid with pending != 0:
  - Pop the mask.
  - If mask[1], write N,Z from alu_flags[3:2]; if mask[0], write C,V from alu_flags[1:0].
  - pending -= 1.
- alu_flags_valid with pending == 0 is ignored.
- Push and pop in the same cycle leave pending unchanged; the FIFO stays ordered.

## Timing
- Reset values:
  - outputs: ex_* = 0, branch_taken = 0, undef_trap = 0, flags = 0000;
  - internal: pending = 0, FIFO empty, state = RUN.
- in_ready is combinational from in_* and registered state.
- All ex_* and branch_taken are registered: 1 cycle after the transfer. ex_valid is 0 when there is no transfer.
- Flags update on the edge after alu_flags_valid. A stalled conditional instruction issues at the earliest in the cycle after pending reaches 0.
- A taken branch in the last cycle of FLUSH cannot occur, because FLUSH never evaluates conditions.
- Reset asserted mid-flush or with pending > 0 discards everything. ALU flags arriving after reset are ignored (pending == 0).

## Configuration
- COND_UNDEF_TRAP_EN defined:
  - A transfer with in_cond = 1111 in RUN pulses undef_trap for one cycle, aligned with ex_valid = 1 and ex_condex = 0.
  - The instruction is squashed.
- Not defined: the undef_trap port is absent, and 1111 is squashed silently.

## Structure
- Package cond_pkg holds:
  - the cond_e enum (16 codes);
  - flags_t, a packed {n,z,c,v};
  - the state_e enum {RUN, FLUSH}.
- Sub-module cond_eval: purely combinational, (cond_e, flags_t) → condex.
- FIFO and counters live inline.

## Test plan
- Reset, then flags = 0000; issue NE with regw = 1 → ex_condex = 1, ex_regw = 1 one cycle later.
- Issue AL with flagw = 11, return alu_flags = 0100 with valid; then an EQ instruction → EQ stalls (in_ready = 0) until the flag edge, then issues with ex_condex = 1.
- AL flag-writers back to back with MAX_PEND = 2 → the third stalls; one alu_flags_valid re-enables it the same cycle.
- flagw = 10 with alu_flags = 1111, starting from flags 0000 → flags = 1100 (CV preserved).
- Taken B (pcs = 1, cond AL), followed by 3 valid instructions → branch_taken pulses, next 2 give ex_valid = 0, the third issues.
- COND_UNDEF_TRAP_EN: cond 1111 → undef_trap = 1 for one cycle, ex_regw = 0; assert reset_n = 0 with pending = 1 → flags = 0000 and pending = 0 immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types for the conditional-issue controller: condition codes, NZCV flags, FSM states.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
      MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
      HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
      GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
   } cond_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against the NZCV flags; code 1111 never passes.
import cond_pkg::*;

module cond_eval (
   input  cond_e  cond,
   input  flags_t flags,
   output logic   condex
);

   always_comb begin
      condex = 1'b0;
      case (cond)
         EQ: condex = flags.z;
         NE: condex = ~flags.z;
         CS: condex = flags.c;
         CC: condex = ~flags.c;
         MI: condex = flags.n;
         PL: condex = ~flags.n;
         VS: condex = flags.v;
         VC: condex = ~flags.v;
         HI: condex = flags.c & ~flags.z;
         LS: condex = ~(flags.c & ~flags.z);
         GE: condex = (flags.n == flags.v);
         LT: condex = (flags.n != flags.v);
         GT: condex = ~flags.z & (flags.n == flags.v);
         LE: condex = ~(~flags.z & (flags.n == flags.v));
         AL: condex = 1'b1;
         NV: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issue-stage controller: owns NZCV, gates side effects by condition, tracks in-flight flag writers.
// Optional COND_UNDEF_TRAP_EN adds the undef_trap pulse for condition code 1111.
import cond_pkg::*;

module cond_issue_ctrl #(
   parameter int MAX_PEND    = 2,
   parameter int FLUSH_SLOTS = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_cond,
   input  logic [1:0] in_flagw,
   input  logic       in_regw,
   input  logic       in_memw,
   input  logic       in_pcs,
   input  logic [3:0] alu_flags,
   input  logic       alu_flags_valid,
   output logic       ex_valid,
   output logic       ex_regw,
   output logic       ex_memw,
   output logic       ex_pcs,
   output logic [1:0] ex_flagw,
   output logic       ex_condex,
   output logic       branch_taken,
   output logic [3:0] flags
`ifdef COND_UNDEF_TRAP_EN
   ,
   output logic       undef_trap
`endif
);

   localparam int PW = $clog2(MAX_PEND + 1);
   localparam int SW = 2;

   state_e                     state_q, state_d;
   logic [PW-1:0]              pend_q, pend_d, wr_idx;
   logic [MAX_PEND-1:0][1:0]   fifo_q, fifo_d;
   logic [SW-1:0]              slots_q, slots_d;
   flags_t                     flags_q, flags_d;

   logic       ex_valid_q, ex_valid_d;
   logic       ex_regw_q, ex_regw_d;
   logic       ex_memw_q, ex_memw_d;
   logic       ex_pcs_q, ex_pcs_d;
   logic [1:0] ex_flagw_q, ex_flagw_d;
   logic       ex_condex_q, ex_condex_d;
   logic       branch_taken_q, branch_taken_d;
   logic       undef_trap_q, undef_trap_d;

   cond_e cond;
   logic  condex, xfer, pop, push;

   assign cond = cond_e'(in_cond);
   assign pop  = alu_flags_valid && (pend_q != '0);
   assign push = (ex_flagw_d != 2'b00);

   cond_eval u_eval (
      .cond   (cond),
      .flags  (flags_q),
      .condex (condex)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         slots_q <= '0;
      end else begin
         state_q <= state_d;
         slots_q <= slots_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      slots_d = slots_q;
      case (state_q)
         RUN: begin
            if (branch_taken_d) begin
               state_d = FLUSH;
               slots_d = SW'(FLUSH_SLOTS);
            end
         end
         FLUSH: begin
            if (xfer) begin
               slots_d = slots_q - SW'(1);
               if (slots_q == SW'(1)) state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs: handshake and next-cycle execute controls
   always_comb begin
      in_ready       = 1'b1;
      ex_valid_d     = 1'b0;
      ex_regw_d      = 1'b0;
      ex_memw_d      = 1'b0;
      ex_pcs_d       = 1'b0;
      ex_flagw_d     = 2'b00;
      ex_condex_d    = 1'b0;
      branch_taken_d = 1'b0;
      undef_trap_d   = 1'b0;
      if (state_q == RUN) begin
         // No flag forwarding: a conditional waits for every pending writer to retire.
         in_ready = !((in_valid && cond != AL && pend_q != '0) ||
                      (in_flagw != 2'b00 && pend_q == PW'(MAX_PEND) && !pop));
      end
      xfer = in_valid && in_ready;
      if (xfer && state_q == RUN) begin
         ex_valid_d     = 1'b1;
         ex_regw_d      = in_regw & condex;
         ex_memw_d      = in_memw & condex;
         ex_pcs_d       = in_pcs & condex;
         ex_flagw_d     = in_flagw & {2{condex}};
         ex_condex_d    = condex;
         branch_taken_d = in_pcs & condex;
         undef_trap_d   = (cond == NV);
      end
   end

   // Flag-mask FIFO (index 0 is oldest) and architectural flags
   always_comb begin
      pend_d  = pend_q + PW'(push) - PW'(pop);
      fifo_d  = fifo_q;
      flags_d = flags_q;
      wr_idx  = pop ? pend_q - PW'(1) : pend_q;
      if (pop) begin
         if (fifo_q[0][1]) {flags_d.n, flags_d.z} = alu_flags[3:2];
         if (fifo_q[0][0]) {flags_d.c, flags_d.v} = alu_flags[1:0];
         for (int i = 0; i < MAX_PEND - 1; i++) fifo_d[i] = fifo_q[i+1];
         fifo_d[MAX_PEND-1] = 2'b00;
      end
      if (push) begin
         for (int i = 0; i < MAX_PEND; i++)
            if (PW'(i) == wr_idx) fifo_d[i] = ex_flagw_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q         <= '0;
         fifo_q         <= '0;
         flags_q        <= '0;
         ex_valid_q     <= 1'b0;
         ex_regw_q      <= 1'b0;
         ex_memw_q      <= 1'b0;
         ex_pcs_q       <= 1'b0;
         ex_flagw_q     <= 2'b00;
         ex_condex_q    <= 1'b0;
         branch_taken_q <= 1'b0;
         undef_trap_q   <= 1'b0;
      end else begin
         pend_q         <= pend_d;
         fifo_q         <= fifo_d;
         flags_q        <= flags_d;
         ex_valid_q     <= ex_valid_d;
         ex_regw_q      <= ex_regw_d;
         ex_memw_q      <= ex_memw_d;
         ex_pcs_q       <= ex_pcs_d;
         ex_flagw_q     <= ex_flagw_d;
         ex_condex_q    <= ex_condex_d;
         branch_taken_q <= branch_taken_d;
         undef_trap_q   <= undef_trap_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_regw      = ex_regw_q;
   assign ex_memw      = ex_memw_q;
   assign ex_pcs       = ex_pcs_q;
   assign ex_flagw     = ex_flagw_q;
   assign ex_condex    = ex_condex_q;
   assign branch_taken = branch_taken_q;
   assign flags        = flags_q;

`ifdef COND_UNDEF_TRAP_EN
   assign undef_trap = undef_trap_q;
`else
   logic unused_undef;
   assign unused_undef = undef_trap_q;
`endif

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed bench for cond_issue_ctrl: expected execute records queued at drive time, checked after the edge.
module tb_cond_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid, in_ready;
   logic [3:0] in_cond;
   logic [1:0] in_flagw;
   logic       in_regw, in_memw, in_pcs;
   logic [3:0] alu_flags;
   logic       alu_flags_valid;
   logic       ex_valid, ex_regw, ex_memw, ex_pcs, ex_condex, branch_taken;
   logic [1:0] ex_flagw;
   logic [3:0] flags;
`ifdef COND_UNDEF_TRAP_EN
   logic       undef_trap;
`endif

   always #5 clk = ~clk;

   cond_issue_ctrl #(.MAX_PEND(2), .FLUSH_SLOTS(2)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_cond         (in_cond),
      .in_flagw        (in_flagw),
      .in_regw         (in_regw),
      .in_memw         (in_memw),
      .in_pcs          (in_pcs),
      .alu_flags       (alu_flags),
      .alu_flags_valid (alu_flags_valid),
      .ex_valid        (ex_valid),
      .ex_regw         (ex_regw),
      .ex_memw         (ex_memw),
      .ex_pcs          (ex_pcs),
      .ex_flagw        (ex_flagw),
      .ex_condex       (ex_condex),
      .branch_taken    (branch_taken),
      .flags           (flags)
`ifdef COND_UNDEF_TRAP_EN
      ,
      .undef_trap      (undef_trap)
`endif
   );

   typedef struct packed {
      logic       v, rw, mw, pc;
      logic [1:0] fw;
      logic       cx, br, ud;
      logic [3:0] fl;
   } exp_t;

   exp_t sbq[$];
   int   errs   = 0;
   int   checks = 0;

   function automatic exp_t E(input logic v, rw, mw, pc, input logic [1:0] fw,
                              input logic cx, br, ud, input logic [3:0] fl);
      exp_t e;
      e.v = v; e.rw = rw; e.mw = mw; e.pc = pc; e.fw = fw;
      e.cx = cx; e.br = br; e.ud = ud; e.fl = fl;
      return e;
   endfunction

   task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
      end
   endtask

   task automatic compare(input string tag);
      exp_t e;
      e = sbq.pop_front();
      chk(tag, "ex_valid",  {3'b0, ex_valid},     {3'b0, e.v});
      chk(tag, "ex_regw",   {3'b0, ex_regw},      {3'b0, e.rw});
      chk(tag, "ex_memw",   {3'b0, ex_memw},      {3'b0, e.mw});
      chk(tag, "ex_pcs",    {3'b0, ex_pcs},       {3'b0, e.pc});
      chk(tag, "ex_flagw",  {2'b0, ex_flagw},     {2'b0, e.fw});
      chk(tag, "ex_condex", {3'b0, ex_condex},    {3'b0, e.cx});
      chk(tag, "branch",    {3'b0, branch_taken}, {3'b0, e.br});
      chk(tag, "flags",     flags,                e.fl);
`ifdef COND_UNDEF_TRAP_EN
      chk(tag, "undef",     {3'b0, undef_trap},   {3'b0, e.ud});
`endif
   endtask

   // Drive one cycle of inputs, check the handshake, queue the expected execute record, compare after the edge.
   task automatic step(input string tag, input logic v, input logic [3:0] cond, input logic [1:0] fw,
                       input logic rw, mw, pc, afv, input logic [3:0] af, input logic rdy, input exp_t e);
      in_valid = v; in_cond = cond; in_flagw = fw;
      in_regw = rw; in_memw = mw; in_pcs = pc;
      alu_flags_valid = afv; alu_flags = af;
      #1;
      chk(tag, "in_ready", {3'b0, in_ready}, {3'b0, rdy});
      sbq.push_back(e);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      in_valid = 0; in_cond = 4'hE; in_flagw = 0; in_regw = 0; in_memw = 0; in_pcs = 0;
      alu_flags = 0; alu_flags_valid = 0;
      #3;
      chk("reset", "in_ready", {3'b0, in_ready}, 4'h1);
      sbq.push_back(E(0,0,0,0,2'b00,0,0,0,4'h0));
      compare("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      //   tag       v  cond  fw     rw mw pc afv af    rdy expected
      step("ne",     1, 4'h1, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,1,0,0,2'b00,1,0,0,4'h0));
      step("eq_f",   1, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b00,0,0,0,4'h0));
      step("fw11",   1, 4'hE, 2'b11, 1, 0, 0, 0, 4'h0, 1, E(1,1,0,0,2'b11,1,0,0,4'h0));
      step("haz1",   1, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 0, E(0,0,0,0,2'b00,0,0,0,4'h0));
      step("haz2",   1, 4'h0, 2'b00, 1, 0, 0, 1, 4'h4, 0, E(0,0,0,0,2'b00,0,0,0,4'h4));
      step("eq_t",   1, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,1,0,0,2'b00,1,0,0,4'h4));
      step("fw10",   1, 4'hE, 2'b10, 0, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b10,1,0,0,4'h4));
      step("fw01",   1, 4'hE, 2'b01, 0, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b01,1,0,0,4'h4));
      step("full",   1, 4'hE, 2'b11, 0, 0, 0, 0, 4'h0, 0, E(0,0,0,0,2'b00,0,0,0,4'h4));
      step("fullpop",1, 4'hE, 2'b11, 0, 0, 0, 1, 4'hF, 1, E(1,0,0,0,2'b11,1,0,0,4'hC));
      step("pop01",  0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h3, 1, E(0,0,0,0,2'b00,0,0,0,4'hF));
      step("pop11",  0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h0, 1, E(0,0,0,0,2'b00,0,0,0,4'h0));
      step("nz_only",1, 4'hE, 2'b10, 0, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b10,1,0,0,4'h0));
      step("nz_pop", 0, 4'hE, 2'b00, 0, 0, 0, 1, 4'hF, 1, E(0,0,0,0,2'b00,0,0,0,4'hC));
      step("stray",  0, 4'hE, 2'b00, 0, 0, 0, 1, 4'h3, 1, E(0,0,0,0,2'b00,0,0,0,4'hC));
      step("br",     1, 4'hE, 2'b00, 0, 0, 1, 0, 4'h0, 1, E(1,0,0,1,2'b00,1,1,0,4'hC));
      step("flush1", 1, 4'hA, 2'b00, 1, 1, 0, 0, 4'h0, 1, E(0,0,0,0,2'b00,0,0,0,4'hC));
      step("flush2", 1, 4'hE, 2'b11, 1, 0, 0, 0, 4'h0, 1, E(0,0,0,0,2'b00,0,0,0,4'hC));
      step("gt_f",   1, 4'hC, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b00,0,0,0,4'hC));
      step("al_rw",  1, 4'hE, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,1,0,0,2'b00,1,0,0,4'hC));
      step("br_nt",  1, 4'h1, 2'b00, 0, 0, 1, 0, 4'h0, 1, E(1,0,0,0,2'b00,0,0,0,4'hC));
      step("al_mw",  1, 4'hE, 2'b00, 0, 1, 0, 0, 4'h0, 1, E(1,0,1,0,2'b00,1,0,0,4'hC));
      step("undef",  1, 4'hF, 2'b00, 1, 1, 0, 0, 4'h0, 1, E(1,0,0,0,2'b00,0,0,1,4'hC));
      step("pre_rst",1, 4'hE, 2'b11, 0, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b11,1,0,0,4'hC));

      // Asynchronous reset while one flag writer is pending
      in_valid = 1; in_cond = 4'h0; in_flagw = 0; alu_flags_valid = 0;
      reset_n = 1'b0;
      #1;
      chk("async_rst", "in_ready", {3'b0, in_ready}, 4'h1);
      sbq.push_back(E(0,0,0,0,2'b00,0,0,0,4'h0));
      compare("async_rst");
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      step("late_alu",0, 4'hE, 2'b00, 0, 0, 0, 1, 4'hF, 1, E(0,0,0,0,2'b00,0,0,0,4'h0));
      step("eq_post", 1, 4'h0, 2'b00, 1, 0, 0, 0, 4'h0, 1, E(1,0,0,0,2'b00,0,0,0,4'h0));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
